// File: rtl/clock_select_ctrl.sv
// Control-domain sequencer for the glitch-free clock mux select, with optional target liveness
// check before switching (enabled by defining CLKSEL_LIVENESS_EN).
module clock_select_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned WINDOW_CYCLES = 64,
  parameter int unsigned MIN_EDGES     = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic clk_0_mon,
  input  logic clk_1_mon,
  output logic sel,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [1:0] {StIdle, StCheck, StSwitch, StSettle} state_e;

  localparam logic [CNT_W-1:0] SettleInit = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             target_q, target_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] settle_q, settle_d;

`ifdef CLKSEL_LIVENESS_EN
  localparam logic [CNT_W-1:0] WindowLen = CNT_W'(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] MinEdges  = CNT_W'(MIN_EDGES);

  logic             err_q, err_d;
  logic [CNT_W-1:0] win_q, win_d, win_inc;
  logic [CNT_W-1:0] edge_q, edge_d, edge_inc;
  // Per monitor: [0] first sync flop, [1] second sync flop, [2] delay flop.
  logic [2:0]       mon0_q, mon1_q;
  logic             tgt_rise;

  assign tgt_rise = target_q ? (mon1_q[1] & ~mon1_q[2]) : (mon0_q[1] & ~mon0_q[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      win_q  <= '0;
      edge_q <= '0;
      mon0_q <= '0;
      mon1_q <= '0;
    end else begin
      err_q  <= err_d;
      win_q  <= win_d;
      edge_q <= edge_d;
      mon0_q <= {mon0_q[1:0], clk_0_mon};
      mon1_q <= {mon1_q[1:0], clk_1_mon};
    end
  end
`else
  logic unused_mon;
  assign unused_mon = clk_0_mon ^ clk_1_mon;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= 1'b0;
      target_q <= 1'b0;
      done_q   <= 1'b0;
      settle_q <= '0;
    end else begin
      sel_q    <= sel_d;
      target_q <= target_d;
      done_q   <= done_d;
      settle_q <= settle_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    target_d = target_q;
    done_d   = 1'b0;
    settle_d = settle_q;
`ifdef CLKSEL_LIVENESS_EN
    err_d    = 1'b0;
    win_d    = win_q;
    edge_d   = edge_q;
    win_inc  = win_q + CntOne;
    edge_inc = edge_q + {{(CNT_W-1){1'b0}}, tgt_rise};
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_sel == sel_q) begin
            done_d = 1'b1;
          end else begin
            target_d = req_sel;
`ifdef CLKSEL_LIVENESS_EN
            state_d  = StCheck;
            win_d    = '0;
            edge_d   = '0;
`else
            state_d  = StSwitch;
`endif
          end
        end
      end
      StCheck: begin
`ifdef CLKSEL_LIVENESS_EN
        win_d  = win_inc;
        edge_d = edge_inc;
        // Enough edges wins over an expiring window in the same cycle.
        if (edge_inc >= MinEdges) begin
          state_d = StSwitch;
        end else if (win_inc >= WindowLen) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
`else
        state_d = StIdle;
`endif
      end
      StSwitch: begin
        sel_d    = target_q;
        settle_d = SettleInit;
        state_d  = StSettle;
      end
      StSettle: begin
        settle_d = settle_q - CntOne;
        if (settle_d == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    sel       = sel_q;
    done      = done_q;
`ifdef CLKSEL_LIVENESS_EN
    err       = err_q;
`else
    err       = 1'b0;
`endif
  end

endmodule

// File: tb/tb_clock_select_ctrl.sv
// Self-checking bench for clock_select_ctrl; expected done/err pulses are queued per request
// and popped when the DUT pulses.
module tb_clock_select_ctrl;
  localparam int S = 16;
  localparam int W = 64;
  localparam int M = 4;

  logic clk = 1'b0;
  logic rst, req_valid, req_sel, req_ready, clk_0_mon, clk_1_mon, sel, busy, done, err;
  int   total = 0;
  int   bad   = 0;

  logic       mon1_run = 1'b0;
  logic [2:0] mon_ph   = 3'd0;

  typedef struct {
    bit is_err;
    int cmin;
    int cmax;
    bit sel;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) mon_ph <= mon_ph + 3'd1;
  // clk_1_mon rises every 8 cycles when running; clk_0_mon rises every 4 cycles.
  assign clk_1_mon = mon1_run & mon_ph[2];
  assign clk_0_mon = mon_ph[1];

  clock_select_ctrl #(
    .SETTLE_CYCLES(S),
    .WINDOW_CYCLES(W),
    .MIN_EDGES    (M),
    .CNT_W        (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_sel  (req_sel),
    .req_ready(req_ready),
    .clk_0_mon(clk_0_mon),
    .clk_1_mon(clk_1_mon),
    .sel      (sel),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_sel = 1'b0; mon1_run = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({sel, req_ready, busy, done, err} !== 5'b01000) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d {sel,ready,busy,done,err} got=%b want=01000",
                 i, {sel, req_ready, busy, done, err});
      end
    end
  endtask

  // Issues one request and watches until its pulse (cycle k counted from acceptance).
  task automatic run_req(input bit rsel, input bit exp_err, input int cmin, input int cmax,
                         input bit exp_sel, input int sw_cycle, input bit noop, input string nm);
    exp_t e;
    bit   old_sel;
    bit   seen;
    int   seen_k;
    @(negedge clk);
    old_sel = sel;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL %s ready_before got=%b want=1", nm, req_ready);
    end
    e = '{is_err: exp_err, cmin: cmin, cmax: cmax, sel: exp_sel};
    sb.push_back(e);
    req_valid = 1'b1; req_sel = rsel;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0; seen_k = 0;
    for (int k = 1; k <= 200 && !(seen && k > seen_k + 3); k++) begin
      @(negedge clk);
      total++;
      if (done && err) begin
        bad++; $display("FAIL %s done_and_err cyc=%0d got=11 want=not both", nm, k);
      end
      if (noop) begin
        total++;
        if ({busy, req_ready} !== 2'b01) begin
          bad++; $display("FAIL %s noop_busy cyc=%0d {busy,ready} got=%b want=01", nm, k,
                          {busy, req_ready});
        end
      end else if (!seen && !(done || err)) begin
        total++;
        if ({busy, req_ready} !== 2'b10) begin
          bad++; $display("FAIL %s busy cyc=%0d {busy,ready} got=%b want=10", nm, k,
                          {busy, req_ready});
        end
      end
      if (sw_cycle > 0 && !seen) begin
        total++;
        if (sel !== ((k >= sw_cycle) ? rsel : old_sel)) begin
          bad++; $display("FAIL %s sel_timing cyc=%0d got=%b want=%b", nm, k, sel,
                          (k >= sw_cycle) ? rsel : old_sel);
        end
      end
      if (done || err) begin
        total++;
        if (seen) begin
          bad++; $display("FAIL %s extra_pulse cyc=%0d got=pulse want=none", nm, k);
        end else if (sb.size() == 0) begin
          bad++; $display("FAIL %s unexpected_pulse cyc=%0d got=pulse want=none", nm, k);
        end else begin
          e = sb.pop_front();
          seen = 1'b1; seen_k = k;
          if (err !== e.is_err) begin
            bad++; $display("FAIL %s pulse_kind got err=%b want err=%b", nm, err, e.is_err);
          end
          total++;
          if (k < e.cmin || k > e.cmax) begin
            bad++; $display("FAIL %s pulse_cycle got=%0d want=%0d..%0d", nm, k, e.cmin, e.cmax);
          end
          total++;
          if (sel !== e.sel) begin
            bad++; $display("FAIL %s sel_at_pulse got=%b want=%b", nm, sel, e.sel);
          end
          total++;
          if ({busy, req_ready} !== 2'b01) begin
            bad++; $display("FAIL %s ready_at_pulse {busy,ready} got=%b want=01", nm,
                            {busy, req_ready});
          end
        end
      end
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL %s timeout got=no pulse want=pulse", nm);
      sb.delete();
    end
  endtask

  task automatic test_noop(input bit s);
    run_req(s, 1'b0, 1, 1, s, 0, 1'b1, "noop");
  endtask

`ifdef CLKSEL_LIVENESS_EN
  task automatic test_liveness_fail();
    mon1_run = 1'b0;
    repeat (4) @(posedge clk);
    run_req(1'b1, 1'b1, W + 1, W + 1, 1'b0, 0, 1'b0, "liveness_fail");
  endtask

  task automatic test_switch();
    mon1_run = 1'b1;
    repeat (20) @(posedge clk);
    // CHECK lasts 25..32 cycles depending on edge phase, then SWITCH + SETTLE.
    run_req(1'b1, 1'b0, S + 2 + 25, S + 2 + 32, 1'b1, 0, 1'b0, "switch_to_1");
    // clk_0_mon rises every 4 cycles: CHECK lasts 13..16 cycles.
    run_req(1'b0, 1'b0, S + 2 + 13, S + 2 + 16, 1'b0, 0, 1'b0, "switch_to_0");
  endtask
`else
  task automatic test_switch();
    run_req(1'b1, 1'b0, S + 2, S + 2, 1'b1, 2, 1'b0, "switch_to_1");
    run_req(1'b0, 1'b0, S + 2, S + 2, 1'b0, 2, 1'b0, "switch_to_0");
  endtask
`endif

  task automatic test_reset_mid();
    int k;
    mon1_run = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_sel = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    while (sel !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (sel !== 1'b1) begin
      bad++; $display("FAIL reset_mid reach_settle got sel=%b want=1", sel);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({sel, req_ready, busy, done, err} !== 5'b01000) begin
      bad++; $display("FAIL reset_mid after_rst {sel,ready,busy,done,err} got=%b want=01000",
                      {sel, req_ready, busy, done, err});
    end
    for (int i = 0; i < S + 5; i++) begin
      @(negedge clk);
      total++;
      if ({sel, done, err} !== 3'b000) begin
        bad++; $display("FAIL reset_mid quiet cyc=%0d {sel,done,err} got=%b want=000", i,
                        {sel, done, err});
      end
    end
  endtask

  initial begin
    test_reset();
    test_noop(1'b0);
`ifdef CLKSEL_LIVENESS_EN
    test_liveness_fail();
`endif
    test_switch();
    run_req(1'b1, 1'b0, S + 2, S + 2 + 40, 1'b1, 0, 1'b0, "switch_again");
    test_noop(1'b1);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
